// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM issue stage feeding an external ALU, 2-stage elastic pipe
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake
//   opcode, funct3, funct7     decoded instruction fields
//   rs1_val, rs2_val, imm      source operands / sign-extended I-immediate
//   alu_a, alu_b, alu_op       registered operands and op code to the ALU
//   alu_result                 combinational ALU result
//   out_valid/out_ready        downstream handshake
//   out_result, out_illegal    registered result and illegal-encoding flag
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [XLEN-1:0] SIGN_BIT = {1'b1, {(XLEN-1){1'b0}}};

  logic            s1_valid;
  logic            s1_illegal;
  logic            s2_ready;
  logic            accept;
  logic            s1_xfer;

  logic            is_op;
  logic            is_imm;
  logic            f7_legal;
  logic            legal;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_op;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign s1_xfer  = s1_valid && s2_ready;

  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);

  // The alternate funct7 encoding is only meaningful for add/sub and srl/sra.
  assign f7_legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  // OP-IMM only carries funct7 semantics on shifts; elsewhere it is immediate bits.
  always_comb begin
    legal = 1'b0;
    if (is_op)
      legal = f7_legal;
    else if (is_imm)
      legal = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? f7_legal : 1'b1;
  end

  always_comb begin
    dec_a  = rs1_val;
    dec_b  = is_op ? rs2_val : imm;
    dec_op = ALU_ADD;
    case (funct3)
      3'b000: dec_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: dec_op = ALU_SLL;
      3'b010: begin
        // Signed compare via unsigned compare of sign-flipped operands.
        dec_op = ALU_SLTU;
        dec_a  = rs1_val ^ SIGN_BIT;
        dec_b  = (is_op ? rs2_val : imm) ^ SIGN_BIT;
      end
      3'b011: dec_op = ALU_SLTU;
      3'b100: dec_op = ALU_XOR;
      3'b101: dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: dec_op = ALU_OR;
      3'b111: dec_op = ALU_AND;
      default: dec_op = ALU_ADD;
    endcase
    if ((funct3 == 3'b001) || (funct3 == 3'b101))
      dec_b = {{(XLEN-5){1'b0}}, dec_b[4:0]};
    // Illegal ops still flow through as 0 + 0 so the result reads as zero.
    if (!legal) begin
      dec_a  = '0;
      dec_b  = '0;
      dec_op = ALU_ADD;
    end
  end

  // Stage 1: decoded operands; alu_* hold their last values when s1 empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= ALU_ADD;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_illegal <= !legal;
        alu_a      <= dec_a;
        alu_b      <= dec_b;
        alu_op     <= dec_op;
      end else if (s1_xfer) begin
        s1_valid   <= 1'b0;
      end
    end
  end

  // Stage 2: captured ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (s1_xfer) begin
        out_valid   <= 1'b1;
        out_result  <= alu_result;
        out_illegal <= s1_illegal;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU
module tb_alu_issue;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] imm = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_illegal;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  // Stand-in for the shared alu_control datapath.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a << alu_b[4:0];
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1000: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e[31:0]);
        chk("out_illegal", {31'b0, out_illegal}, {31'b0, e[32]});
      end
    end
  end

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] res, input logic ill);
    bit acc;
    acc = 0;
    opcode = opc; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back({ill, res});
    else chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: out_valid low just after accept, high after the next edge.
    send(OP, 3'b000, 7'b0000000, 32'd10, 32'd20, 32'd0, 32'd30, 1'b0);
    chk("lat_after_accept", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_next_edge", {31'b0, out_valid}, 32'd1);

    send(OP, 3'b000, 7'b0100000, 32'd10, 32'd20, 32'd0, 32'hFFFF_FFF6, 1'b0);
    send(OP, 3'b011, 7'b0000000, 32'd10, 32'd20, 32'd0, 32'd1, 1'b0);
    send(OP, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0);
    chk("slt_alu_op", {28'b0, alu_op}, 32'd8);
    chk("slt_alu_a", alu_a, 32'h7FFF_FFFF);
    send(OP, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    send(IMM, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'hF800_0000, 1'b0);
    chk("srai_alu_b", alu_b, 32'd4);
    send(OP, 3'b001, 7'b0000000, 32'd3, 32'h21, 32'd0, 32'd6, 1'b0);
    send(OP, 3'b000, 7'b0000001, 32'd7, 32'd9, 32'd0, 32'd0, 1'b1);
    send(7'b0000011, 3'b000, 7'b0000000, 32'd7, 32'd9, 32'd5, 32'd0, 1'b1);
    send(IMM, 3'b000, 7'b1111111, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd2, 1'b0);
    drain();

    // Backpressure: two ops fill s2 and s1, then in_ready drops.
    out_ready = 1'b0;
    send(OP, 3'b100, 7'b0000000, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'h0000_FF00, 1'b0);
    send(OP, 3'b110, 7'b0000000, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    held = out_result;
    @(negedge clk);
    chk("stall_result_stable", out_result, held);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(OP, 3'b111, 7'b0000000, 32'hFF, 32'h0F, 32'd0, 32'h0F, 1'b0);
        send(OP, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'd0, 32'd1, 1'b0);
      end
    join
    drain();

    // Reset mid-flight discards the op sitting in s1.
    send(OP, 3'b000, 7'b0000000, 32'd100, 32'd23, 32'd0, 32'd123, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_s1_valid", {31'b0, dut.s1_valid}, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(OP, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
